// File: rtl/cpu_pkg.sv
// Shared constants and types for the 8-bit accumulator CPU.
package cpu_pkg;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // Instruction opcodes (instr[7:5])
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Control sequencer states; one instruction walks FETCH -> READ -> EXEC.
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_READ   = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_if.sv
// Datapath bundle between the CPU core (master) and its ALU (slave).
interface cpu_if;

  logic [2:0]              opcode;
  logic [cpu_pkg::DW-1:0]  ac;
  logic [cpu_pkg::DW-1:0]  rvalue;
  logic [cpu_pkg::DW-1:0]  ac_next;
  logic                    is_zero;

  modport master (output opcode, ac, rvalue, input  ac_next, is_zero);
  modport slave  (input  opcode, ac, rvalue, output ac_next, is_zero);

endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: next accumulator value and zero flag of the current one.
module cpu_alu
  import cpu_pkg::*;
(
  cpu_if.slave bus
);

  // Select next accumulator value from the opcode
  always_comb begin
    // NOTE: default assignment first so every path writes ac_next; no latch.
    bus.ac_next = bus.ac;
    case (bus.opcode)
      OP_ADD:  bus.ac_next = bus.ac + bus.rvalue;  // carry out discarded
      OP_AND:  bus.ac_next = bus.ac & bus.rvalue;
      OP_XOR:  bus.ac_next = bus.ac ^ bus.rvalue;
      OP_LDA:  bus.ac_next = bus.rvalue;
      default: bus.ac_next = bus.ac;               // HLT/SKZ/STO/JMP keep ac
    endcase
  end

  // SKZ condition: accumulator currently zero
  assign bus.is_zero = (bus.ac == '0);

endmodule

// File: rtl/cpu.sv
// Top: memory, program counter and FETCH/READ/EXEC sequencer.
module cpu
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,   // asynchronous, active low
  output logic HALT
);

  // Architectural state; names are fixed so the bench can reach them.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] ac;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic [DW-1:0] rvalue;
  logic [2:0]    opcode;
  logic [AW-1:0] operand;
  logic          halt_q;

  state_t        state_q, state_d;
  logic          fetch_en, read_en, exec_en;
  logic [AW-1:0] pc_d;

  assign opcode  = instr[7:5];
  assign operand = instr[4:0];
  assign HALT    = halt_q;

  cpu_if alu_bus ();

  assign alu_bus.opcode = opcode;
  assign alu_bus.ac     = ac;
  assign alu_bus.rvalue = rvalue;

  cpu_alu u_alu (
    .bus (alu_bus)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_READ;
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = (opcode == OP_HLT) ? S_HALTED : S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // Sequencer outputs: one load enable per phase
  always_comb begin
    fetch_en = 1'b0;
    read_en  = 1'b0;
    exec_en  = 1'b0;
    case (state_q)
      S_FETCH: fetch_en = 1'b1;
      S_READ:  read_en  = 1'b1;
      S_EXEC:  exec_en  = 1'b1;
      default: ;
    endcase
  end

  // Next program counter for the instruction in EXEC (5-bit wrap is natural)
  always_comb begin
    pc_d = pc + AW'(1);
    case (opcode)
      OP_HLT:  pc_d = pc;  // stays on the HLT instruction
      OP_SKZ:  pc_d = alu_bus.is_zero ? pc + AW'(2) : pc + AW'(1);
      OP_JMP:  pc_d = operand;
      default: ;
    endcase
  end

  // Datapath registers: instruction, operand value, accumulator, pc, halt flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr  <= '0;
      rvalue <= '0;
      ac     <= '0;
      pc     <= '0;
      halt_q <= 1'b0;
    end else begin
      if (fetch_en) instr  <= mem[pc];
      if (read_en)  rvalue <= mem[operand];
      if (exec_en) begin
        ac <= alu_bus.ac_next;
        pc <= pc_d;
        if (opcode == OP_HLT) halt_q <= 1'b1;
      end
    end
  end

  // Unified memory write port (STO); reads above are combinational
  always_ff @(posedge clk) begin
    // NOTE: memory has no reset so preloaded programs survive rst; it also maps to plain RAM.
    if (exec_en && opcode == OP_STO) mem[operand] <= ac;
  end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for the accumulator CPU: ALU vector table, directed
// programs, async reset, and random programs against an ISA-level model.
module tb_cpu;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic HALT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu dut (
    .clk  (clk),
    .rst  (rst),
    .HALT (HALT)
  );

  // Standalone ALU driven straight from the vector table.
  cpu_if alu_tb_if ();
  cpu_alu u_alu_tb (
    .bus (alu_tb_if)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] ac;
    logic [7:0] rv;
    logic [7:0] exp_ac;
    logic       exp_zero;
  } alu_vec_t;

  alu_vec_t alu_vecs [13];

  // ISA-level model state
  logic [7:0] m_mem [32];
  logic [7:0] m_ac;
  logic [4:0] m_pc;
  logic       m_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [2:0] op, input int a);
    logic [4:0] addr;
    addr = a[4:0];
    return {op, addr};
  endfunction

  task automatic hold_reset();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) dut.mem[i] = 8'h00;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step_instr();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_until_halt(input int max_cycles, input string name);
    int c;
    c = 0;
    while (HALT !== 1'b1 && c < max_cycles) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({name, " halt reached"}, 32'(HALT), 32'd1);
  endtask

  // Executes whole instructions on the model; returns how many retired.
  task automatic model_run(input int max_instr, output int n_done);
    logic [7:0] ins;
    logic [2:0] op;
    logic [4:0] a;
    n_done = 0;
    while (!m_halt && n_done < max_instr) begin
      ins = m_mem[m_pc];
      op  = ins[7:5];
      a   = ins[4:0];
      n_done++;
      if (op == OP_HLT) begin
        m_halt = 1'b1;
      end else if (op == OP_JMP) begin
        m_pc = a;
      end else begin
        if (op == OP_SKZ && m_ac == 8'h00) m_pc = m_pc + 5'd2;
        else                               m_pc = m_pc + 5'd1;
        case (op)
          OP_ADD: m_ac = 8'((int'(m_ac) + int'(m_mem[a])) % 256);
          OP_AND: m_ac = m_ac & m_mem[a];
          OP_XOR: m_ac = m_ac ^ m_mem[a];
          OP_LDA: m_ac = m_mem[a];
          OP_STO: m_mem[a] = m_ac;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    int n_done;

    // ---------------- ALU vector table ----------------
    alu_vecs[0]  = '{OP_ADD, 8'h55, 8'h0F, 8'h64, 1'b0};
    alu_vecs[1]  = '{OP_ADD, 8'hFF, 8'h02, 8'h01, 1'b0};
    alu_vecs[2]  = '{OP_ADD, 8'h00, 8'h00, 8'h00, 1'b1};
    alu_vecs[3]  = '{OP_AND, 8'h64, 8'h0F, 8'h04, 1'b0};
    alu_vecs[4]  = '{OP_AND, 8'hF0, 8'h0F, 8'h00, 1'b0};
    alu_vecs[5]  = '{OP_XOR, 8'h04, 8'h55, 8'h51, 1'b0};
    alu_vecs[6]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0};
    alu_vecs[7]  = '{OP_LDA, 8'h12, 8'h34, 8'h34, 1'b0};
    alu_vecs[8]  = '{OP_LDA, 8'h00, 8'h80, 8'h80, 1'b1};
    alu_vecs[9]  = '{OP_STO, 8'h33, 8'h77, 8'h33, 1'b0};
    alu_vecs[10] = '{OP_SKZ, 8'h00, 8'h09, 8'h00, 1'b1};
    alu_vecs[11] = '{OP_JMP, 8'h7E, 8'h01, 8'h7E, 1'b0};
    alu_vecs[12] = '{OP_HLT, 8'h01, 8'hC3, 8'h01, 1'b0};

    for (int i = 0; i < 13; i++) begin
      alu_tb_if.opcode = alu_vecs[i].op;
      alu_tb_if.ac     = alu_vecs[i].ac;
      alu_tb_if.rvalue = alu_vecs[i].rv;
      #1;
      check($sformatf("alu[%0d] ac_next", i), 32'(alu_tb_if.ac_next), 32'(alu_vecs[i].exp_ac));
      check($sformatf("alu[%0d] is_zero", i), 32'(alu_tb_if.is_zero), 32'(alu_vecs[i].exp_zero));
    end

    // ---------------- Reset / halt on all-zero memory ----------------
    hold_reset();
    check("reset HALT", 32'(HALT), 32'd0);
    check("reset pc", 32'(dut.pc), 32'd0);
    check("reset ac", 32'(dut.ac), 32'd0);
    release_reset();
    repeat (2) @(posedge clk);
    #1;
    check("HALT low before EXEC", 32'(HALT), 32'd0);
    @(posedge clk);
    #1;
    check("zero-mem HALT", 32'(HALT), 32'd1);
    check("zero-mem pc", 32'(dut.pc), 32'd0);
    check("zero-mem ac", 32'(dut.ac), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("zero-mem HALT held", 32'(HALT), 32'd1);
    check("zero-mem pc held", 32'(dut.pc), 32'd0);

    // ---------------- Arithmetic program ----------------
    hold_reset();
    dut.mem[20] = 8'h55;
    dut.mem[21] = 8'h0F;
    dut.mem[0]  = enc(OP_LDA, 20);
    dut.mem[1]  = enc(OP_ADD, 21);
    dut.mem[2]  = enc(OP_AND, 21);
    dut.mem[3]  = enc(OP_XOR, 20);
    dut.mem[4]  = enc(OP_HLT, 0);
    release_reset();
    step_instr(); check("arith ac after LDA", 32'(dut.ac), 32'h55);
    step_instr(); check("arith ac after ADD", 32'(dut.ac), 32'h64);
    step_instr(); check("arith ac after AND", 32'(dut.ac), 32'h04);
    step_instr(); check("arith ac after XOR", 32'(dut.ac), 32'h51);
    check("arith HALT before HLT", 32'(HALT), 32'd0);
    step_instr();
    check("arith HALT", 32'(HALT), 32'd1);
    check("arith pc", 32'(dut.pc), 32'd4);

    // Async reset while halted clears immediately, mid-cycle
    #2 rst = 1'b0;
    #1;
    check("async rst clears HALT", 32'(HALT), 32'd0);
    check("async rst clears ac", 32'(dut.ac), 32'd0);

    // ---------------- STO / overflow ----------------
    hold_reset();
    dut.mem[20] = 8'hFF;
    dut.mem[21] = 8'h02;
    dut.mem[0]  = enc(OP_LDA, 20);
    dut.mem[1]  = enc(OP_ADD, 21);
    dut.mem[2]  = enc(OP_STO, 22);
    dut.mem[3]  = enc(OP_HLT, 0);
    release_reset();
    run_until_halt(40, "sto");
    check("sto mem[22]", 32'(dut.mem[22]), 32'h01);
    check("sto ac", 32'(dut.ac), 32'h01);
    check("sto pc", 32'(dut.pc), 32'd3);

    // ---------------- SKZ / JMP, zero and nonzero ac ----------------
    for (int pass = 0; pass < 2; pass++) begin
      hold_reset();
      dut.mem[30] = (pass == 0) ? 8'h00 : 8'h05;
      dut.mem[0]  = enc(OP_LDA, 30);
      dut.mem[1]  = enc(OP_SKZ, 0);
      dut.mem[2]  = enc(OP_HLT, 0);
      dut.mem[3]  = enc(OP_JMP, 10);
      dut.mem[10] = enc(OP_HLT, 0);
      release_reset();
      run_until_halt(60, $sformatf("skz pass%0d", pass));
      check($sformatf("skz pass%0d halt pc", pass), 32'(dut.pc), (pass == 0) ? 32'd10 : 32'd2);
    end

    // ---------------- PC wrap: JMP 31, SKZ at 31 ----------------
    for (int pass = 0; pass < 2; pass++) begin
      hold_reset();
      dut.mem[30] = (pass == 0) ? 8'h07 : 8'h00;
      dut.mem[0]  = enc(OP_LDA, 30);
      dut.mem[1]  = enc(OP_JMP, 31);
      dut.mem[31] = enc(OP_SKZ, 0);
      release_reset();
      repeat (3) step_instr();
      check($sformatf("wrap pass%0d pc", pass), 32'(dut.pc), (pass == 0) ? 32'd0 : 32'd1);
      step_instr();
      check($sformatf("wrap pass%0d refetch", pass), 32'(dut.instr),
            (pass == 0) ? 32'(enc(OP_LDA, 30)) : 32'(enc(OP_JMP, 31)));
    end

    // ---------------- Self-modifying code ----------------
    hold_reset();
    dut.mem[20] = enc(OP_JMP, 12);
    dut.mem[0]  = enc(OP_LDA, 20);
    dut.mem[1]  = enc(OP_STO, 2);
    dut.mem[2]  = enc(OP_HLT, 0);
    dut.mem[12] = enc(OP_HLT, 0);
    release_reset();
    run_until_halt(60, "selfmod");
    check("selfmod halt pc", 32'(dut.pc), 32'd12);

    // ---------------- Async reset during READ ----------------
    hold_reset();
    dut.mem[20] = 8'h55;
    dut.mem[21] = 8'h0F;
    dut.mem[0]  = enc(OP_LDA, 20);
    dut.mem[1]  = enc(OP_ADD, 21);
    dut.mem[2]  = enc(OP_AND, 21);
    dut.mem[3]  = enc(OP_XOR, 20);
    dut.mem[4]  = enc(OP_HLT, 0);
    release_reset();
    step_instr();
    step_instr();
    @(posedge clk);        // FETCH of instruction 2 done, now in READ
    #2 rst = 1'b0;
    #1;
    check("mid rst pc", 32'(dut.pc), 32'd0);
    check("mid rst ac", 32'(dut.ac), 32'd0);
    check("mid rst HALT", 32'(HALT), 32'd0);
    check("mid rst mem[20]", 32'(dut.mem[20]), 32'h55);
    check("mid rst mem[2]", 32'(dut.mem[2]), 32'(enc(OP_AND, 21)));
    release_reset();
    step_instr();
    check("restart ac after LDA", 32'(dut.ac), 32'h55);
    run_until_halt(60, "restart");
    check("restart final ac", 32'(dut.ac), 32'h51);
    check("restart final pc", 32'(dut.pc), 32'd4);

    // ---------------- Random programs vs ISA model ----------------
    for (int t = 0; t < 25; t++) begin
      hold_reset();
      for (int i = 0; i < 32; i++) begin
        m_mem[i]    = 8'($urandom);
        dut.mem[i]  = m_mem[i];
      end
      m_ac   = 8'h00;
      m_pc   = 5'd0;
      m_halt = 1'b0;
      model_run(30, n_done);
      release_reset();
      repeat (3 * n_done) @(posedge clk);
      #1;
      check($sformatf("rand%0d ac", t), 32'(dut.ac), 32'(m_ac));
      check($sformatf("rand%0d pc", t), 32'(dut.pc), 32'(m_pc));
      check($sformatf("rand%0d HALT", t), 32'(HALT), 32'(m_halt));
      for (int i = 0; i < 32; i++)
        check($sformatf("rand%0d mem[%0d]", t, i), 32'(dut.mem[i]), 32'(m_mem[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
